up_down_count_monitor: RTL and testbench
========================================

# up_down_count_monitor

Downstream companion to the 4-bit up/down counter. Samples the counter's output `q` and its control inputs, and extends the count to a 12-bit position. It flags wrap-around events and illegal steps, and raises a one-shot hit when the extended position reaches a programmed target. It is purely an observer: it never drives the counter.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  Single clock. Shared with the counter; all state updates on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `cnt_rst`  in  1  Counter's `rst` input, tapped from the same net.
- `load_in`  in  1  Counter's `load` input.
- `mode_in`  in  1  Counter's `mode` input: 0 = up, 1 = down.
- `q_in`  in  4  Counter output `q`.
- `target`  in  12  Match value for the extended position.
- `arm`  in  1  One-cycle pulse that arms the match.
- `clr_err`  in  1  Clears the sticky step error.
- `ext_count`  out  12  Extended position; `[3:0]` mirrors the last sampled `q_in`.
- `wrap_up`  out  1  One-cycle pulse on a 15→0 step in up mode.
- `wrap_down`  out  1  One-cycle pulse on a 0→15 step in down mode.
- `ext_ovf`  out  1  One-cycle pulse when `ext_count` wraps 4095→0 or 0→4095.
- `step_err`  out  1  Sticky: an observed step matched none of the legal transitions.
- `armed`  out  1  High while the match FSM is in ARMED.
- `hit`  out  1  One-cycle pulse on match.

## Operation
- Control inputs are registered each edge as `cnt_rst_q`, `load_q` and `mode_q`.
  - The counter acts on them at edge k−1; the monitor sees the result at edge k.
  - These registered copies therefore describe the transition visible in `q_in` at edge k.
- Tracking FSM has two states: INIT and TRACK.
  - INIT (after reset): the first edge sets `ext_count <= {8'h00, q_in}`, performs no checks, and moves to TRACK.
- In TRACK, with `prev = ext_count[3:0]`, the first matching rule below applies (priority order):
  1. `cnt_rst_q=1`: `ext_count <= 12'h000`. If `q_in != 0`, set `step_err`.
  2. `load_q=1`: `ext_count <= {8'h00, q_in}`. Any value of `q_in` is legal.
  3. `mode_q=0`: the legal step is `q_in == prev+1` (mod 16). If `prev==15`, increment the upper 8 bits and pulse `wrap_up`.
  4. `mode_q=1`: the legal step is `q_in == prev−1` (mod 16). If `prev==0`, decrement the upper 8 bits and pulse `wrap_down`.
- Illegal step, including a hold (`q_in == prev`): set `step_err` and resync the low nibble to `q_in`. The upper bits are unchanged and no wrap pulse is issued.
- Upper-byte arithmetic is modulo 256.
  - `ext_ovf` pulses with `wrap_up` when the upper byte goes 0xFF→0x00.
  - `ext_ovf` pulses with `wrap_down` when the upper byte goes 0x00→0xFF.
- `step_err` stays high until `rst` or `clr_err`.
  - A `clr_err` arriving in the same cycle as a new error: the error wins, so `step_err` stays 1.
- Match FSM has three states: IDLE, ARMED and HIT.
  - `arm` moves any state to ARMED; `arm` while already ARMED stays ARMED.
  - In ARMED, if the next value of `ext_count` equals `target`, go to HIT and pulse `hit`.
  - HIT holds until the next `arm`.
  - `arm` and a match in the same cycle: the match is checked in the following cycle, and `hit` never fires on the arming edge.
  - `armed` is high only while in ARMED.

## Timing
- Reset values:
  - `ext_count=0`; all pulse outputs 0; `step_err=0`.
  - Tracking FSM in INIT; match FSM in IDLE with `armed=0`.
  - Registered control copies (`cnt_rst_q`, `load_q`, `mode_q`) are 0.
- Latency: `ext_count`, the wrap pulses, `ext_ovf` and `hit` are all registered. They update on the same edge that samples `q_in`, with no additional stage.
- `rst` asserted mid-operation clears everything immediately (asynchronously). The first edge after release is treated as INIT.
- `target` and `clr_err` are sampled synchronously. `target` may change while armed; the new value applies from the next edge.

## Test plan
- Reset and first sample: `rst` pulse, `q_in=5` → all outputs 0 during reset. The first edge after release gives `ext_count=0x005` with `step_err=0`.
- Up wrap: `mode=0`, `q_in` = 14, 15, 0, 1 → `wrap_up` pulses once, at the 0 sample. `ext_count` goes 0x00E, 0x00F, 0x010, 0x011.
- Down wrap and extended overflow: from `ext_count=0x001`, `mode=1`, `q_in` = 0, 15 → `wrap_down` pulses and `ext_count=0xFFF`; `ext_ovf` pulses on the same cycle.
- Load and counter reset: `load_in=1` with `q_in` becoming 3 → `ext_count=0x003` with no error. Then `cnt_rst=1`, next `q_in=0` → `ext_count=0x000`.
- Illegal step: `mode=0`, `q_in` 4→7 → `step_err=1` and `ext_count[3:0]=7`. `step_err` holds until `clr_err`, then returns to 0.
- Match: `target=0x012`, pulse `arm`, count up from 0x00F → `hit` pulses exactly once, on the cycle `ext_count=0x012`. The FSM stays in HIT and `armed` drops; re-arming is required for another hit.

Source files
------------

// File: rtl/up_down_count_monitor_if.sv
// Signal bundle between a 4-bit up/down counter tap and its monitor.
// The master side supplies the counter taps and the match/error controls.
`timescale 1ns/1ps
interface up_down_count_monitor_if;
    logic        cnt_rst;
    logic        load_in;
    logic        mode_in;
    logic [3:0]  q_in;
    logic [11:0] target;
    logic        arm;
    logic        clr_err;
    logic [11:0] ext_count;
    logic        wrap_up;
    logic        wrap_down;
    logic        ext_ovf;
    logic        step_err;
    logic        armed;
    logic        hit;

    modport master (
        output cnt_rst, load_in, mode_in, q_in, target, arm, clr_err,
        input  ext_count, wrap_up, wrap_down, ext_ovf, step_err, armed, hit
    );

    modport slave (
        input  cnt_rst, load_in, mode_in, q_in, target, arm, clr_err,
        output ext_count, wrap_up, wrap_down, ext_ovf, step_err, armed, hit
    );
endinterface

// File: rtl/up_down_count_monitor.sv
// Passive observer of a 4-bit up/down counter: extends q to a 12-bit position,
// flags wraps and illegal steps, and raises a one-shot hit on a programmed target.
`timescale 1ns/1ps
module up_down_count_monitor (
    input  logic                    clk,
    input  logic                    rst,
    up_down_count_monitor_if.slave  bus
);

    typedef enum logic {INIT, TRACK} trk_t;
    typedef enum logic [1:0] {IDLE, ARMED, HIT} mst_t;

    trk_t        trk_q, trk_d;
    mst_t        mst_q, mst_d;
    logic        cnt_rst_q, load_q, mode_q;
    logic [11:0] ext_q, ext_d;
    logic        wu_q, wu_d;
    logic        wd_q, wd_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        hit_q, hit_d;
    logic        err_set;
    logic [3:0]  prev;
    logic [7:0]  hi;

    assign prev = ext_q[3:0];
    assign hi   = ext_q[11:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_q     <= INIT;
            mst_q     <= IDLE;
            cnt_rst_q <= 1'b0;
            load_q    <= 1'b0;
            mode_q    <= 1'b0;
            ext_q     <= 12'h000;
            wu_q      <= 1'b0;
            wd_q      <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            trk_q     <= trk_d;
            mst_q     <= mst_d;
            cnt_rst_q <= bus.cnt_rst;
            load_q    <= bus.load_in;
            mode_q    <= bus.mode_in;
            ext_q     <= ext_d;
            wu_q      <= wu_d;
            wd_q      <= wd_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            hit_q     <= hit_d;
        end
    end

    // Tracking: the registered controls describe the step now visible on q_in.
    always_comb begin
        trk_d   = TRACK;
        ext_d   = ext_q;
        wu_d    = 1'b0;
        wd_d    = 1'b0;
        ovf_d   = 1'b0;
        err_set = 1'b0;
        case (trk_q)
            INIT: begin
                ext_d = {8'h00, bus.q_in};
            end
            TRACK: begin
                if (cnt_rst_q) begin
                    ext_d   = 12'h000;
                    err_set = (bus.q_in != 4'd0);
                end else if (load_q) begin
                    ext_d = {8'h00, bus.q_in};
                end else if (!mode_q) begin
                    if (bus.q_in == prev + 4'd1) begin
                        if (prev == 4'hF) begin
                            ext_d = {hi + 8'd1, bus.q_in};
                            wu_d  = 1'b1;
                            ovf_d = (hi == 8'hFF);
                        end else begin
                            ext_d = {hi, bus.q_in};
                        end
                    end else begin
                        ext_d   = {hi, bus.q_in};
                        err_set = 1'b1;
                    end
                end else begin
                    if (bus.q_in == prev - 4'd1) begin
                        if (prev == 4'h0) begin
                            ext_d = {hi - 8'd1, bus.q_in};
                            wd_d  = 1'b1;
                            ovf_d = (hi == 8'h00);
                        end else begin
                            ext_d = {hi, bus.q_in};
                        end
                    end else begin
                        ext_d   = {hi, bus.q_in};
                        err_set = 1'b1;
                    end
                end
            end
            default: trk_d = INIT;
        endcase
        // A fresh error outranks a simultaneous clear.
        err_d = err_set ? 1'b1 : (bus.clr_err ? 1'b0 : err_q);
    end

    // Match: compares the position being written this edge, so hit aligns with ext_count.
    always_comb begin
        mst_d = mst_q;
        hit_d = 1'b0;
        if (bus.arm) begin
            mst_d = ARMED;
        end else if (mst_q == ARMED && ext_d == bus.target) begin
            mst_d = HIT;
            hit_d = 1'b1;
        end
    end

    assign bus.ext_count = ext_q;
    assign bus.wrap_up   = wu_q;
    assign bus.wrap_down = wd_q;
    assign bus.ext_ovf   = ovf_q;
    assign bus.step_err  = err_q;
    assign bus.armed     = (mst_q == ARMED);
    assign bus.hit       = hit_q;

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Scoreboard bench for up_down_count_monitor: directed scenarios then random
// counter traffic, checked against a position-level reference model.
`timescale 1ns/1ps
module tb_up_down_count_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    up_down_count_monitor_if bus();

    up_down_count_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [11:0] ext;
        logic        wu;
        logic        wd;
        logic        ov;
        logic        err;
        logic        armed;
        logic        hit;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    // Reference model: position as a plain integer modulo 4096.
    bit          m_init;
    int          m_pos;
    bit          m_err, m_armed;
    bit          m_pcr, m_pld, m_pmd;
    logic [11:0] tgt;

    // Stimulus-side memory of what the real counter would do next.
    bit          l_cr, l_ld, l_md;
    logic [3:0]  l_d, l_q;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] nq();
        if (l_cr) return 4'd0;
        if (l_ld) return l_d;
        if (l_md) return l_q - 4'd1;
        return l_q + 4'd1;
    endfunction

    task automatic model_reset();
        m_init = 1; m_pos = 0; m_err = 0; m_armed = 0;
        m_pcr = 0; m_pld = 0; m_pmd = 0;
        l_cr = 0; l_ld = 0; l_md = 0; l_d = 4'd0; l_q = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_ext_count", bus.ext_count, 0);
        chk("rst_wrap_up",   bus.wrap_up,   0);
        chk("rst_wrap_down", bus.wrap_down, 0);
        chk("rst_ext_ovf",   bus.ext_ovf,   0);
        chk("rst_step_err",  bus.step_err,  0);
        chk("rst_armed",     bus.armed,     0);
        chk("rst_hit",       bus.hit,       0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic tick(input bit cr, input bit ld, input bit md, input logic [3:0] d,
                        input logic [3:0] q, input bit ar, input bit ce);
        exp_t e;
        int   lo;
        int   qi;
        bit   eset;
        @(negedge clk);
        bus.cnt_rst = cr;
        bus.load_in = ld;
        bus.mode_in = md;
        bus.q_in    = q;
        bus.target  = tgt;
        bus.arm     = ar;
        bus.clr_err = ce;
        e    = '0;
        eset = 0;
        qi   = int'(q);
        lo   = m_pos % 16;
        if (m_init) begin
            m_pos  = qi;
            m_init = 0;
        end else if (m_pcr) begin
            eset  = (qi != 0);
            m_pos = 0;
        end else if (m_pld) begin
            m_pos = qi;
        end else if (!m_pmd) begin
            if (qi == (lo + 1) % 16) begin
                e.wu  = (lo == 15);
                e.ov  = (m_pos == 4095);
                m_pos = (m_pos + 1) % 4096;
            end else begin
                eset  = 1;
                m_pos = m_pos - lo + qi;
            end
        end else begin
            if (qi == (lo + 15) % 16) begin
                e.wd  = (lo == 0);
                e.ov  = (m_pos == 0);
                m_pos = (m_pos + 4095) % 4096;
            end else begin
                eset  = 1;
                m_pos = m_pos - lo + qi;
            end
        end
        m_err = eset ? 1'b1 : (ce ? 1'b0 : m_err);
        if (ar) begin
            m_armed = 1;
        end else if (m_armed && m_pos == int'(tgt)) begin
            m_armed = 0;
            e.hit   = 1;
        end
        e.ext   = 12'(m_pos);
        e.err   = m_err;
        e.armed = m_armed;
        m_pcr = cr; m_pld = ld; m_pmd = md;
        l_cr = cr; l_ld = ld; l_md = md; l_d = d; l_q = q;
        sbq.push_back(e);
    endtask

    // Monitor: pops one expectation per edge that the driver scheduled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("ext_count", bus.ext_count, e.ext);
                chk("wrap_up",   bus.wrap_up,   e.wu);
                chk("wrap_down", bus.wrap_down, e.wd);
                chk("ext_ovf",   bus.ext_ovf,   e.ov);
                chk("step_err",  bus.step_err,  e.err);
                chk("armed",     bus.armed,     e.armed);
                chk("hit",       bus.hit,       e.hit);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         cr, ld, md, ar, ce;
        logic [3:0] d, q;
        bus.cnt_rst = 0; bus.load_in = 0; bus.mode_in = 0; bus.q_in = 4'd5;
        bus.target = 12'h000; bus.arm = 0; bus.clr_err = 0;
        tgt = 12'hABC;
        model_reset();
        do_reset();

        // First sample, then up wrap 14,15,0,1
        tick(0, 0, 0, 4'd0, 4'd5, 0, 0);
        tick(0, 1, 0, 4'd14, nq(), 0, 0);
        tick(0, 0, 0, 4'd0, nq(), 0, 0);
        tick(0, 0, 0, 4'd0, nq(), 0, 0);
        tick(0, 0, 0, 4'd0, nq(), 0, 0);
        tick(0, 0, 0, 4'd0, nq(), 0, 0);
        // Counter reset, load 1, then down through 0 to 0xFFF
        tick(1, 0, 0, 4'd0, nq(), 0, 0);
        tick(0, 1, 1, 4'd1, nq(), 0, 0);
        tick(0, 0, 1, 4'd0, nq(), 0, 0);
        tick(0, 0, 1, 4'd0, nq(), 0, 0);
        tick(0, 0, 1, 4'd0, nq(), 0, 0);
        // Load 4, illegal jump to 7, clear behaviour
        tick(0, 1, 0, 4'd4, nq(), 0, 0);
        tick(0, 0, 0, 4'd0, nq(), 0, 0);
        tick(0, 0, 0, 4'd0, 4'd7, 0, 0);
        tick(0, 0, 0, 4'd0, nq(), 0, 0);
        tick(0, 0, 0, 4'd0, nq(), 0, 1);
        tick(0, 0, 0, 4'd0, l_q, 0, 1);
        tick(0, 0, 0, 4'd0, nq(), 0, 1);
        // Match at 0x012, then no re-fire without re-arming
        tick(1, 0, 0, 4'd0, nq(), 0, 0);
        tick(0, 1, 0, 4'd15, nq(), 0, 0);
        tgt = 12'h012;
        tick(0, 0, 0, 4'd0, nq(), 1, 0);
        repeat (4) tick(0, 0, 0, 4'd0, nq(), 0, 0);
        tgt = 12'h014;
        tick(0, 0, 0, 4'd0, nq(), 0, 0);
        // Arm on the matching edge: hit must wait for the next match
        tgt = 12'h015;
        tick(0, 0, 0, 4'd0, nq(), 1, 0);
        tick(0, 0, 0, 4'd0, nq(), 0, 0);
        tgt = 12'h017;
        tick(0, 0, 0, 4'd0, nq(), 0, 0);

        md = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cr = ($urandom_range(0, 99) < 4);
            ld = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 10) md = ~md;
            d  = 4'($urandom);
            q  = nq();
            if ($urandom_range(0, 99) < 6) q = 4'($urandom);
            ar = ($urandom_range(0, 99) < 7);
            if (ar) tgt = 12'((m_pos + int'($urandom_range(0, 5))) % 4096);
            else if ($urandom_range(0, 99) < 3) tgt = 12'((m_pos + int'($urandom_range(0, 3))) % 4096);
            ce = ($urandom_range(0, 99) < 5);
            tick(cr, ld, md, d, q, ar, ce);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
